cp0_exc_seq: RTL and testbench
==============================

// Module: cp0_exc_seq
// PURPOSE
//  Exception/interrupt sequencer in front of the CP0 register block. Detects pending
//  interrupts and MEM-stage exceptions/ERET, prioritises them, then drives the CP0
//  single write port through a fixed sequence (EPC, Status). It also pulses a Cause
//  side-band, flushes the pipeline and redirects the PC. In IDLE it forwards
//  pipeline MTC0 writes to CP0 unchanged.
// PARAMETERS
//  EXC_VECTOR   32'h0000_0020  handler entry PC for every exception/interrupt
//  ADDR_STATUS  5'd12          CP0 Status address; use `CP0_REG_STATUS
//  ADDR_EPC     5'd14          CP0 EPC address; use `CP0_REG_EPC
// PORTS
//  clk              in   1   clock
//  rst              in   1   reset, synchronous, active-high
//  inst_valid_i     in   1   MEM stage holds a real, non-bubble instruction
//  excepttype_i     in   32  [8]syscall [9]RI [10]trap [11]ov [12]eret; other bits ignored
//  inst_addr_i      in   32  PC of MEM-stage instruction
//  in_delayslot_i   in   1   MEM-stage instruction is in a branch delay slot
//  status_i         in   32  current CP0 Status
//  cause_i          in   32  current CP0 Cause (IP in [15:8])
//  epc_i            in   32  current CP0 EPC
//  mtc0_we_i        in   1   pipeline CP0 write request
//  mtc0_addr_i      in   5   pipeline CP0 write address
//  mtc0_data_i      in   32  pipeline CP0 write data
//  cp0_we_o         out  1   CP0 write enable
//  cp0_waddr_o      out  5   CP0 write address
//  cp0_data_o       out  32  CP0 write data
//  cause_upd_o      out  1   1-cycle pulse: CP0 latches BD/ExcCode
//  cause_bd_o       out  1   Cause.BD value, valid with cause_upd_o
//  cause_code_o     out  5   Cause.ExcCode value, valid with cause_upd_o
//  stall_o          out  1   hold pipeline while sequencing
//  flush_o          out  1   1-cycle flush of all stages
//  new_pc_o         out  32  redirect target, valid with flush_o
// BEHAVIOUR
//  - Reset: state IDLE, all latches 0; every output 0 in the cycle after the reset edge.
//    Reset in any state aborts the sequence; no partial write is completed.
//  - Interrupt pending: |(cause_i[15:8] & status_i[15:8]) & status_i[0] & ~status_i[1].
//  - take = inst_valid_i & (int pending | any of excepttype_i[12:8]); evaluated only in IDLE.
//  - Priority and ExcCode: int 0x00 > syscall 0x08 > RI 0x0a > trap 0x0d > ov 0x0c > eret.
//  - On take, latch at edge T: code, kind (exc/eret), status_i, epc_i, and
//    bd = in_delayslot_i. EPC value = bd ? inst_addr_i-4 : inst_addr_i (mod 2^32).
//  - FSM (Moore outputs): IDLE -> W_EPC -> W_STATUS -> REDIRECT -> IDLE.
//    eret path: IDLE -> W_STATUS -> REDIRECT -> IDLE.
//    * W_EPC: we=1, addr=ADDR_EPC, data=EPC value; cause_upd_o=1 with bd and code.
//      If latched Status.EXL=1 (nested), the we/addr/data write is suppressed
//      (cp0_we_o=0) and cause_upd_o is still pulsed with bd and code.
//    * W_STATUS: we=1, addr=ADDR_STATUS, data=status_q | 32'h2 (exc) or
//      status_q & ~32'h2 (eret).
//    * REDIRECT: flush_o=1; new_pc_o=EXC_VECTOR (exc) or latched epc_i (eret).
//  - stall_o=1 in W_EPC, W_STATUS and REDIRECT. Latency take->flush: 3 cycles (exc),
//    2 cycles (eret).
//  - MTC0 forwarding, IDLE only: cp0_* = mtc0_* combinationally, gated by ~take.
//    An MTC0 in the take cycle is dropped. MTC0 requests outside IDLE are ignored;
//    the pipeline is stalled or flushed.
//  - New exceptions/interrupts arriving outside IDLE are not sampled; they are
//    re-evaluated after return to IDLE.
// STRUCTURE
//  - Shared defines file: ExcCode constants, excepttype bit positions, FSM state encoding
//    (2-bit), EXC_VECTOR default. CP0 addresses come from the existing defines.
//  - One sub-module, exc_prio_enc: combinational priority encoder (pending, excepttype ->
//    take, code, is_eret). The FSM and latches stay in cp0_exc_seq.
// TESTING
//  - Syscall: excepttype=0x100, addr=0x1000, bd=0, status=0x1000_0001 -> T+1 EPC<=0x1000,
//    code 0x08, bd=0; T+2 Status<=0x1000_0003; T+3 flush, new_pc=0x20.
//  - Delay slot: RI at addr=0x2004, bd=1 -> EPC<=0x2000, cause_bd_o=1, code 0x0a.
//  - Interrupt: cause[15:8]=0x80, status=0x0000_8001 -> code 0x00. With status[0]=0 ->
//    no take, mtc0 forwarded.
//  - ERET: excepttype=0x1000, epc_i=0x3000, status=0x3 -> no cause_upd; T+1 Status<=0x1;
//    T+2 flush, new_pc=0x3000.
//  - Simultaneous: syscall+ov+mtc0 in one cycle -> code 0x08, mtc0 dropped.
//    Nested (EXL=1) -> no EPC write.
//  - Reset asserted in W_STATUS -> next cycle all outputs 0; fresh syscall afterwards
//    sequences normally.

Source files
------------

// File: rtl/cp0_exc_seq_pkg.sv
// rtl/cp0_exc_seq_pkg.sv - shared constants and state encoding for the CP0 exception sequencer
package cp0_exc_seq_pkg;

  localparam logic [4:0]  CP0_REG_STATUS = 5'd12;
  localparam logic [4:0]  CP0_REG_EPC    = 5'd14;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCCODE_RI   = 5'h0a;
  localparam logic [4:0] EXCCODE_OV   = 5'h0c;
  localparam logic [4:0] EXCCODE_TRAP = 5'h0d;

  localparam int ET_SYSCALL = 8;
  localparam int ET_RI      = 9;
  localparam int ET_TRAP    = 10;
  localparam int ET_OV      = 11;
  localparam int ET_ERET    = 12;

  localparam int STATUS_EXL = 1;
  localparam int STATUS_IE  = 0;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_W_EPC    = 2'd1,
    S_W_STATUS = 2'd2,
    S_REDIRECT = 2'd3
  } seq_state_e;

endpackage

// File: rtl/cp0_exc_seq_prio_enc.sv
// rtl/cp0_exc_seq_prio_enc.sv - priority encoder: interrupt > syscall > RI > trap > ov > eret
module exc_prio_enc
  import cp0_exc_seq_pkg::*;
(
  input  logic        inst_valid_i,
  input  logic        int_pending_i,
  input  logic [31:0] excepttype_i,
  output logic        take_o,
  output logic [4:0]  code_o,
  output logic        is_eret_o
);

  logic unused_et;
  assign unused_et = ^{excepttype_i[31:13], excepttype_i[7:0]};

  always_comb begin
    take_o    = 1'b0;
    code_o    = EXCCODE_INT;
    is_eret_o = 1'b0;
    if (inst_valid_i) begin
      if (int_pending_i) begin
        take_o = 1'b1;
        code_o = EXCCODE_INT;
      end else if (excepttype_i[ET_SYSCALL]) begin
        take_o = 1'b1;
        code_o = EXCCODE_SYS;
      end else if (excepttype_i[ET_RI]) begin
        take_o = 1'b1;
        code_o = EXCCODE_RI;
      end else if (excepttype_i[ET_TRAP]) begin
        take_o = 1'b1;
        code_o = EXCCODE_TRAP;
      end else if (excepttype_i[ET_OV]) begin
        take_o = 1'b1;
        code_o = EXCCODE_OV;
      end else if (excepttype_i[ET_ERET]) begin
        take_o    = 1'b1;
        is_eret_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exc_seq.sv
// rtl/cp0_exc_seq.sv - sequences EPC/Status writes, Cause pulse, flush and PC redirect on exceptions
module cp0_exc_seq
  import cp0_exc_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
  parameter logic [4:0]  ADDR_STATUS = CP0_REG_STATUS,
  parameter logic [4:0]  ADDR_EPC    = CP0_REG_EPC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] inst_addr_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        mtc0_we_i,
  input  logic [4:0]  mtc0_addr_i,
  input  logic [31:0] mtc0_data_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_data_o,
  output logic        cause_upd_o,
  output logic        cause_bd_o,
  output logic [4:0]  cause_code_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  seq_state_e  state_q, state_d;
  logic [4:0]  code_q;
  logic        eret_q;
  logic        bd_q;
  logic [31:0] status_q;
  logic [31:0] epc_in_q;
  logic [31:0] epc_val_q;

  logic        int_pending;
  logic        enc_take;
  logic        enc_eret;
  logic [4:0]  enc_code;
  logic        take;
  logic        unused_cause;

  assign unused_cause = ^{cause_i[31:16], cause_i[7:0]};

  assign int_pending = (|(cause_i[15:8] & status_i[15:8])) & status_i[STATUS_IE]
                       & ~status_i[STATUS_EXL];

  exc_prio_enc u_prio (
    .inst_valid_i  (inst_valid_i),
    .int_pending_i (int_pending),
    .excepttype_i  (excepttype_i),
    .take_o        (enc_take),
    .code_o        (enc_code),
    .is_eret_o     (enc_eret)
  );

  // Sampling is confined to IDLE; anything arriving mid-sequence waits for the return.
  assign take = enc_take & (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      code_q    <= '0;
      eret_q    <= 1'b0;
      bd_q      <= 1'b0;
      status_q  <= '0;
      epc_in_q  <= '0;
      epc_val_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        code_q    <= enc_code;
        eret_q    <= enc_eret;
        bd_q      <= in_delayslot_i;
        status_q  <= status_i;
        epc_in_q  <= epc_i;
        epc_val_q <= in_delayslot_i ? (inst_addr_i - 32'd4) : inst_addr_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (take) state_d = enc_eret ? S_W_STATUS : S_W_EPC;
      S_W_EPC:    state_d = S_W_STATUS;
      S_W_STATUS: state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cp0_we_o     = 1'b0;
    cp0_waddr_o  = '0;
    cp0_data_o   = '0;
    cause_upd_o  = 1'b0;
    cause_bd_o   = 1'b0;
    cause_code_o = '0;
    stall_o      = 1'b0;
    flush_o      = 1'b0;
    new_pc_o     = '0;
    case (state_q)
      S_IDLE: begin
        if (mtc0_we_i && !take) begin
          cp0_we_o    = 1'b1;
          cp0_waddr_o = mtc0_addr_i;
          cp0_data_o  = mtc0_data_i;
        end
      end
      S_W_EPC: begin
        stall_o      = 1'b1;
        cause_upd_o  = 1'b1;
        cause_bd_o   = bd_q;
        cause_code_o = code_q;
        // Nested exception keeps the original EPC.
        if (!status_q[STATUS_EXL]) begin
          cp0_we_o    = 1'b1;
          cp0_waddr_o = ADDR_EPC;
          cp0_data_o  = epc_val_q;
        end
      end
      S_W_STATUS: begin
        stall_o     = 1'b1;
        cp0_we_o    = 1'b1;
        cp0_waddr_o = ADDR_STATUS;
        cp0_data_o  = eret_q ? (status_q & ~32'h2) : (status_q | 32'h2);
      end
      S_REDIRECT: begin
        stall_o  = 1'b1;
        flush_o  = 1'b1;
        new_pc_o = eret_q ? epc_in_q : EXC_VECTOR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_seq.sv
// tb/tb_cp0_exc_seq.sv - vector table plus expected-output queue for cp0_exc_seq
module tb_cp0_exc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i;
  logic [31:0] excepttype_i, inst_addr_i, status_i, cause_i, epc_i, mtc0_data_i;
  logic        in_delayslot_i, mtc0_we_i;
  logic [4:0]  mtc0_addr_i;
  logic        cp0_we_o, cause_upd_o, cause_bd_o, stall_o, flush_o;
  logic [4:0]  cp0_waddr_o, cause_code_o;
  logic [31:0] cp0_data_o, new_pc_o;

  always #5 clk = ~clk;

  cp0_exc_seq dut (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .excepttype_i(excepttype_i),
    .inst_addr_i(inst_addr_i), .in_delayslot_i(in_delayslot_i), .status_i(status_i),
    .cause_i(cause_i), .epc_i(epc_i), .mtc0_we_i(mtc0_we_i), .mtc0_addr_i(mtc0_addr_i),
    .mtc0_data_i(mtc0_data_i), .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o),
    .cp0_data_o(cp0_data_o), .cause_upd_o(cause_upd_o), .cause_bd_o(cause_bd_o),
    .cause_code_o(cause_code_o), .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  typedef struct packed {
    logic        strict;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        upd;
    logic        bd;
    logic [4:0]  code;
    logic        stall;
    logic        flush;
    logic [31:0] pc;
  } obs_t;

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] et;
    logic [31:0] addr;
    logic        bd;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        mwe;
    logic [4:0]  maddr;
    logic [31:0] mdata;
    logic        hold;
    logic        take;
    logic [4:0]  code;
    logic        eret;
  } vec_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  function automatic obs_t mk(logic we, logic [4:0] a, logic [31:0] d, logic upd, logic bd,
                              logic [4:0] code, logic stall, logic flush, logic [31:0] pc);
    obs_t o;
    o = '{strict: 1'b0, we: we, addr: a, data: d, upd: upd, bd: bd, code: code,
          stall: stall, flush: flush, pc: pc};
    return o;
  endfunction

  // Fields qualified by a valid bit are only compared while that bit is set.
  function automatic obs_t qual(obs_t o);
    obs_t r = o;
    r.strict = 1'b0;
    if (!r.we) begin r.addr = '0; r.data = '0; end
    if (!r.upd) begin r.bd = 1'b0; r.code = '0; end
    if (!r.flush) r.pc = '0;
    return r;
  endfunction

  task automatic check(input string name);
    obs_t a, e;
    a = mk(cp0_we_o, cp0_waddr_o, cp0_data_o, cause_upd_o, cause_bd_o, cause_code_o,
           stall_o, flush_o, new_pc_o);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: no expected entry queued", name);
      return;
    end
    e = exp_q.pop_front();
    if (!e.strict) begin
      a = qual(a);
      e = qual(e);
    end
    e.strict = 1'b0;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s: got we=%0b a=%0d d=%h upd=%0b bd=%0b c=%h st=%0b fl=%0b pc=%h; want we=%0b a=%0d d=%h upd=%0b bd=%0b c=%h st=%0b fl=%0b pc=%h",
               name, a.we, a.addr, a.data, a.upd, a.bd, a.code, a.stall, a.flush, a.pc,
               e.we, e.addr, e.data, e.upd, e.bd, e.code, e.stall, e.flush, e.pc);
    end
  endtask

  task automatic clear_inputs();
    inst_valid_i = 1'b0; excepttype_i = '0; inst_addr_i = '0; in_delayslot_i = 1'b0;
    status_i = '0; cause_i = '0; epc_i = '0;
    mtc0_we_i = 1'b0; mtc0_addr_i = '0; mtc0_data_i = '0;
  endtask

  task automatic drive(input vec_t v);
    inst_valid_i = v.valid; excepttype_i = v.et; inst_addr_i = v.addr; in_delayslot_i = v.bd;
    status_i = v.status; cause_i = v.cause; epc_i = v.epc;
    mtc0_we_i = v.mwe; mtc0_addr_i = v.maddr; mtc0_data_i = v.mdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic apply_vec(input vec_t v);
    logic [31:0] epcv, st_new;
    drive(v);
    if (v.take) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    else        exp_q.push_back(mk(v.mwe, v.maddr, v.mdata, 0, 0, 0, 0, 0, 0));
    @(negedge clk); check({v.name, ":idle"});
    next_cycle();
    if (!v.hold) clear_inputs();
    if (v.take) begin
      epcv   = v.bd ? v.addr - 32'd4 : v.addr;
      st_new = v.eret ? (v.status & ~32'h2) : (v.status | 32'h2);
      if (!v.eret) begin
        exp_q.push_back(mk(!v.status[1], 5'd14, epcv, 1, v.bd, v.code, 1, 0, 0));
        @(negedge clk); check({v.name, ":w_epc"});
        next_cycle();
      end
      exp_q.push_back(mk(1, 5'd12, st_new, 0, 0, 0, 1, 0, 0));
      @(negedge clk); check({v.name, ":w_status"});
      next_cycle();
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, v.eret ? v.epc : 32'h20));
      @(negedge clk); check({v.name, ":redirect"});
      next_cycle();
      clear_inputs();
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk); check({v.name, ":back_idle"});
      next_cycle();
    end
  endtask

  function automatic vec_t V(string n, logic valid, logic [31:0] et, logic [31:0] addr, logic bd,
                             logic [31:0] st, logic [31:0] ca, logic [31:0] epc, logic mwe,
                             logic [4:0] ma, logic [31:0] md, logic hold, logic take,
                             logic [4:0] code, logic eret);
    vec_t v;
    v = '{name: n, valid: valid, et: et, addr: addr, bd: bd, status: st, cause: ca, epc: epc,
          mwe: mwe, maddr: ma, mdata: md, hold: hold, take: take, code: code, eret: eret};
    return v;
  endfunction

  initial begin
    obs_t z;
    vec_t sv;
    vecs.push_back(V("syscall",   1, 32'h100,  32'h1000, 0, 32'h1000_0001, 0, 0, 0, 0, 0, 0, 1, 5'h08, 0));
    vecs.push_back(V("ri_ds",     1, 32'h200,  32'h2004, 1, 32'h1, 0, 0, 0, 0, 0, 0, 1, 5'h0a, 0));
    vecs.push_back(V("irq",       1, 32'h0,    32'h4000, 0, 32'h8001, 32'h8000, 0, 0, 0, 0, 0, 1, 5'h00, 0));
    vecs.push_back(V("irq_ie0",   1, 32'h0,    32'h4000, 0, 32'h8000, 32'h8000, 0, 1, 5'd12, 32'hdead_beef, 0, 0, 0, 0));
    vecs.push_back(V("eret",      1, 32'h1000, 32'h4100, 0, 32'h3, 0, 32'h3000, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(V("sys_ov_mt", 1, 32'h900,  32'h5000, 0, 32'h1, 0, 0, 1, 5'd9, 32'h55, 1, 1, 5'h08, 0));
    vecs.push_back(V("nested_ov", 1, 32'h800,  32'h6000, 0, 32'h3, 0, 0, 0, 0, 0, 0, 1, 5'h0c, 0));
    vecs.push_back(V("trap_ov",   1, 32'hc00,  32'h6100, 0, 32'h1, 0, 0, 0, 0, 0, 0, 1, 5'h0d, 0));
    vecs.push_back(V("bubble",    0, 32'h100,  32'h6200, 0, 32'h1, 0, 0, 1, 5'd14, 32'h77, 0, 0, 0, 0));
    vecs.push_back(V("exl_eret",  1, 32'h1000, 32'h6300, 0, 32'h0403, 32'h0400, 32'h7000, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(V("irq_nomask",1, 32'h0,    32'h6400, 0, 32'h0201, 32'h0100, 0, 1, 5'd14, 32'h1234, 0, 0, 0, 0));
    vecs.push_back(V("irq_vs_sys",1, 32'h100,  32'h8000, 1, 32'h0201, 32'h0200, 0, 0, 0, 0, 0, 1, 5'h00, 0));
    vecs.push_back(V("ri_wrap",   1, 32'h200,  32'h0,    1, 32'h1, 0, 0, 0, 0, 0, 0, 1, 5'h0a, 0));

    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    z.strict = 1'b1;
    exp_q.push_back(z);
    @(negedge clk); check("reset_outputs");
    next_cycle();
    rst = 1'b0;

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Reset landing in W_STATUS must abort without finishing the sequence.
    sv = V("post_rst_sys", 1, 32'h100, 32'h9000, 0, 32'h1, 0, 0, 0, 0, 0, 0, 1, 5'h08, 0);
    drive(sv);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); check("abort:idle");
    next_cycle();
    clear_inputs();
    exp_q.push_back(mk(1, 5'd14, 32'h9000, 1, 0, 5'h08, 1, 0, 0));
    @(negedge clk); check("abort:w_epc");
    next_cycle();
    exp_q.push_back(mk(1, 5'd12, 32'h3, 0, 0, 0, 1, 0, 0));
    @(negedge clk); check("abort:w_status");
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    exp_q.push_back(z);
    @(negedge clk); check("abort:reset_zero");
    next_cycle();
    exp_q.push_back(z);
    @(negedge clk); check("abort:no_redirect");
    next_cycle();
    apply_vec(sv);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL leftover: %0d expected entries never compared", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
